// File: rtl/ps2_ascii_decoder.sv
// PS/2 scan-code to ASCII decoder: flag synchroniser, prefix/shift FSM, show-ahead FIFO.
// Optional PS2_CAPSLOCK_EN adds a caps_lock toggle on make code 0x58 and a caps_lock port.
module ps2_ascii_decoder #(
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] code,
  input  logic       flag,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       overflow,
  output logic       shift_active
`ifdef PS2_CAPSLOCK_EN
  ,
  output logic       caps_lock
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, BREAK, EXT, EXT_BREAK} state_t;

  logic [SYNC_STAGES-1:0] flag_sync_reg;
  logic                   flag_prev_reg;
  logic                   flag_edge;
  logic                   byte_event_reg;
  logic [7:0]             code_reg;

  state_t     state_reg;
  logic       lshift_reg;
  logic       rshift_reg;
  logic       caps_on;
  logic       push_reg;
  logic [7:0] push_data_reg;

  logic [7:0] xlat_lo;
  logic [7:0] xlat_hi;
  logic       xlat_hit;
  logic       xlat_letter;
  logic       use_upper;

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr_reg;
  logic [AW:0] rd_ptr_reg;
  logic [AW:0] wr_next;
  logic [AW:0] rd_next;
  logic        fifo_empty;
  logic        fifo_full;
  logic        pop;
  logic        wr_en;
  logic [7:0]  out_data_reg;
  logic        overflow_reg;

  // Synchroniser chain plus rising-edge detect; the capture cycle is the byte event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_sync_reg  <= '0;
      flag_prev_reg  <= 1'b0;
      byte_event_reg <= 1'b0;
      code_reg       <= 8'h00;
    end else begin
      flag_sync_reg  <= {flag_sync_reg[SYNC_STAGES-2:0], flag};
      flag_prev_reg  <= flag_sync_reg[SYNC_STAGES-1];
      byte_event_reg <= flag_edge;
      if (flag_edge) code_reg <= code;
    end
  end

  assign flag_edge = flag_sync_reg[SYNC_STAGES-1] & ~flag_prev_reg;

  always_comb begin
    xlat_lo = 8'h00;
    xlat_hi = 8'h00;
    case (code_reg)
      8'h1C: {xlat_lo, xlat_hi} = {"a", "A"};
      8'h32: {xlat_lo, xlat_hi} = {"b", "B"};
      8'h21: {xlat_lo, xlat_hi} = {"c", "C"};
      8'h23: {xlat_lo, xlat_hi} = {"d", "D"};
      8'h24: {xlat_lo, xlat_hi} = {"e", "E"};
      8'h2B: {xlat_lo, xlat_hi} = {"f", "F"};
      8'h34: {xlat_lo, xlat_hi} = {"g", "G"};
      8'h33: {xlat_lo, xlat_hi} = {"h", "H"};
      8'h43: {xlat_lo, xlat_hi} = {"i", "I"};
      8'h3B: {xlat_lo, xlat_hi} = {"j", "J"};
      8'h42: {xlat_lo, xlat_hi} = {"k", "K"};
      8'h4B: {xlat_lo, xlat_hi} = {"l", "L"};
      8'h3A: {xlat_lo, xlat_hi} = {"m", "M"};
      8'h31: {xlat_lo, xlat_hi} = {"n", "N"};
      8'h44: {xlat_lo, xlat_hi} = {"o", "O"};
      8'h4D: {xlat_lo, xlat_hi} = {"p", "P"};
      8'h15: {xlat_lo, xlat_hi} = {"q", "Q"};
      8'h2D: {xlat_lo, xlat_hi} = {"r", "R"};
      8'h1B: {xlat_lo, xlat_hi} = {"s", "S"};
      8'h2C: {xlat_lo, xlat_hi} = {"t", "T"};
      8'h3C: {xlat_lo, xlat_hi} = {"u", "U"};
      8'h2A: {xlat_lo, xlat_hi} = {"v", "V"};
      8'h1D: {xlat_lo, xlat_hi} = {"w", "W"};
      8'h22: {xlat_lo, xlat_hi} = {"x", "X"};
      8'h35: {xlat_lo, xlat_hi} = {"y", "Y"};
      8'h1A: {xlat_lo, xlat_hi} = {"z", "Z"};
      8'h16: {xlat_lo, xlat_hi} = {"1", "!"};
      8'h1E: {xlat_lo, xlat_hi} = {"2", "@"};
      8'h26: {xlat_lo, xlat_hi} = {"3", "#"};
      8'h25: {xlat_lo, xlat_hi} = {"4", "$"};
      8'h2E: {xlat_lo, xlat_hi} = {"5", "%"};
      8'h36: {xlat_lo, xlat_hi} = {"6", "^"};
      8'h3D: {xlat_lo, xlat_hi} = {"7", "&"};
      8'h3E: {xlat_lo, xlat_hi} = {"8", "*"};
      8'h46: {xlat_lo, xlat_hi} = {"9", "("};
      8'h45: {xlat_lo, xlat_hi} = {"0", ")"};
      8'h29: {xlat_lo, xlat_hi} = {8'h20, 8'h20};
      8'h5A: {xlat_lo, xlat_hi} = {8'h0D, 8'h0D};
      8'h66: {xlat_lo, xlat_hi} = {8'h08, 8'h08};
      8'h0D: {xlat_lo, xlat_hi} = {8'h09, 8'h09};
      default: {xlat_lo, xlat_hi} = 16'h0000;
    endcase
  end

  // Every table entry is non-zero, so a zero lower-case byte means "no translation".
  assign xlat_hit    = (xlat_lo != 8'h00);
  assign xlat_letter = (xlat_lo >= 8'h61) && (xlat_lo <= 8'h7A);
  assign use_upper   = xlat_letter ? ((lshift_reg | rshift_reg) ^ caps_on)
                                   : (lshift_reg | rshift_reg);

`ifdef PS2_CAPSLOCK_EN
  logic caps_reg;
  assign caps_on   = caps_reg;
  assign caps_lock = caps_reg;
`else
  assign caps_on = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      lshift_reg    <= 1'b0;
      rshift_reg    <= 1'b0;
      push_reg      <= 1'b0;
      push_data_reg <= 8'h00;
`ifdef PS2_CAPSLOCK_EN
      caps_reg      <= 1'b0;
`endif
    end else begin
      push_reg <= 1'b0;
      if (byte_event_reg) begin
        case (state_reg)
          IDLE: begin
            if (code_reg == 8'hE0) state_reg <= EXT;
            else if (code_reg == 8'hF0) state_reg <= BREAK;
            else if (code_reg == 8'h12) lshift_reg <= 1'b1;
            else if (code_reg == 8'h59) rshift_reg <= 1'b1;
`ifdef PS2_CAPSLOCK_EN
            else if (code_reg == 8'h58) caps_reg <= ~caps_reg;
`endif
            else if (xlat_hit) begin
              push_reg      <= 1'b1;
              push_data_reg <= use_upper ? xlat_hi : xlat_lo;
            end
          end
          BREAK: begin
            if (code_reg == 8'h12) lshift_reg <= 1'b0;
            else if (code_reg == 8'h59) rshift_reg <= 1'b0;
            state_reg <= IDLE;
          end
          EXT:       state_reg <= (code_reg == 8'hF0) ? EXT_BREAK : IDLE;
          EXT_BREAK: state_reg <= IDLE;
          default:   state_reg <= IDLE;
        endcase
      end
    end
  end

  assign shift_active = lshift_reg | rshift_reg;

  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign pop        = !fifo_empty && out_ready;
  assign wr_en      = push_reg && (!fifo_full || pop);
  assign wr_next    = wr_ptr_reg + (AW+1)'(wr_en);
  assign rd_next    = rd_ptr_reg + (AW+1)'(pop);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg[AW-1:0]] <= push_data_reg;
  end

  // out_data is the registered next head; a write landing on the new head slot bypasses memory.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      out_data_reg <= 8'h00;
      overflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_next;
      rd_ptr_reg <= rd_next;
      if (push_reg && fifo_full && !pop) overflow_reg <= 1'b1;
      if (wr_next != rd_next) begin
        if (wr_en && (wr_ptr_reg[AW-1:0] == rd_next[AW-1:0]))
          out_data_reg <= push_data_reg;
        else
          out_data_reg <= mem[rd_next[AW-1:0]];
      end
    end
  end

  assign out_data  = out_data_reg;
  assign out_valid = !fifo_empty;
  assign overflow  = overflow_reg;

endmodule
